// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM states,
// ALU operation/ALUOp encodings, opcodes and datapath mux select codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Datapath mux select codes
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE: return IMM_S;
            OP_BEQ:   return IMM_B;
            OP_JAL:   return IMM_J;
            default:  return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode from ALUOp/funct3/funct7; flags unsupported funct3.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl,
    output logic       illegal_f3
);

    always_comb begin
        ALUControl = ALU_ADD;
        illegal_f3 = 1'b0;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from addi, which must never subtract
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: illegal_f3 = 1'b1;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a multicycle RISC-V core (lw/sw/R/addi-class/jal/beq)
// with optional memory-ready stalls in the fetch and memory access states.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    state_e     state_q, state_d;
    logic       mem_rdy;
    logic [1:0] alu_op;
    logic       pc_update, branch;
    logic       ir_write, reg_write, mem_write;
    logic       illegal_op, illegal_f3, illegal_exec;

    assign mem_rdy = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                ir_write  = mem_rdy;
                pc_update = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Computes the branch/jump target ahead of knowing the opcode
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_dec (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl),
        .illegal_f3 (illegal_f3)
    );

    assign illegal_exec = ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)) & illegal_f3;
    assign ImmSrc       = imm_src_of(op);

    // Write enables are gated by reset so they drop immediately, not at the next edge
    assign PCWrite  = reset_n & (pc_update | (branch & Zero));
    assign IRWrite  = reset_n & ir_write;
    assign RegWrite = reset_n & reg_write;
    assign MemWrite = reset_n & mem_write;
    assign Illegal  = reset_n & (illegal_op | illegal_exec);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Instruction-level checker for multicycle_ctrl: each instruction expands into
// its expected per-cycle output sequence, including random memory stalls.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal)
    );

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] aluc;
        logic       ill;
    } exp_t;

    typedef struct {
        logic mr;
        exp_t e;
    } step_t;

    step_t plan[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'd1;
            7'b1100011: return 2'd2;
            7'b1101111: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    // add/sub/slt/or/and by funct3; only register-register ops may subtract
    function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input exp_t e);
        step_t s;
        s.mr = mr;
        s.e  = e;
        plan.push_back(s);
    endtask

    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fstall, input int mstall);
        exp_t b, e;
        logic legal;
        plan.delete();
        b = '0;
        b.imm = imm_ref(o);
        for (int i = 0; i < fstall; i++) begin
            e = b; e.sb = 2'd2; e.rs = 2'd2;
            push(1'b0, e);
        end
        e = b; e.sb = 2'd2; e.rs = 2'd2; e.irw = 1'b1; e.pcw = 1'b1;
        push(1'b1, e);
        legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
        e = b; e.sa = 2'd1; e.sb = 2'd1; e.ill = !legal;
        push(rnd_bit(), e);
        if (!legal) return;
        case (o)
            7'b0000011, 7'b0100011: begin
                e = b; e.sa = 2'd2; e.sb = 2'd1;
                push(rnd_bit(), e);
                for (int i = 0; i < mstall; i++) begin
                    e = b; e.adr = 1'b1;
                    push(1'b0, e);
                end
                e = b; e.adr = 1'b1; e.memw = (o == 7'b0100011);
                push(1'b1, e);
                if (o == 7'b0000011) begin
                    e = b; e.rs = 2'd1; e.regw = 1'b1;
                    push(rnd_bit(), e);
                end
            end
            7'b0110011, 7'b0010011: begin
                e = b; e.sa = 2'd2; e.sb = (o == 7'b0110011) ? 2'd0 : 2'd1;
                e.aluc = alu_ref(o, f3, f7);
                e.ill  = !(f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
                push(rnd_bit(), e);
                e = b; e.regw = 1'b1;
                push(rnd_bit(), e);
            end
            7'b1101111: begin
                e = b; e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1;
                push(rnd_bit(), e);
                e = b; e.regw = 1'b1;
                push(rnd_bit(), e);
            end
            default: begin
                e = b; e.sa = 2'd2; e.sb = 2'd0; e.aluc = 3'b001; e.pcw = z;
                push(rnd_bit(), e);
            end
        endcase
    endtask

    task automatic compare(input exp_t e, input string ctx);
        check({ctx, ".PCWrite"},    PCWrite,    e.pcw);
        check({ctx, ".AdrSrc"},     AdrSrc,     e.adr);
        check({ctx, ".MemWrite"},   MemWrite,   e.memw);
        check({ctx, ".IRWrite"},    IRWrite,    e.irw);
        check({ctx, ".RegWrite"},   RegWrite,   e.regw);
        check({ctx, ".ResultSrc"},  ResultSrc,  e.rs);
        check({ctx, ".ALUSrcA"},    ALUSrcA,    e.sa);
        check({ctx, ".ALUSrcB"},    ALUSrcB,    e.sb);
        check({ctx, ".ImmSrc"},     ImmSrc,     e.imm);
        check({ctx, ".ALUControl"}, ALUControl, e.aluc);
        check({ctx, ".Illegal"},    Illegal,    e.ill);
    endtask

    // Each step: drive, settle, compare, then advance one clock
    task automatic run(input string ctx, input int n);
        for (int i = 0; i < n && i < plan.size(); i++) begin
            MemReady = plan[i].mr;
            #1;
            compare(plan[i].e, $sformatf("%s[%0d]", ctx, i));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input string ctx, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input int fs, input int ms);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        build(o, f3, f7, z, fs, ms);
        run(ctx, plan.size());
    endtask

    task automatic check_reset_quiet(input string ctx);
        check({ctx, ".PCWrite"},   PCWrite,   1'b0);
        check({ctx, ".IRWrite"},   IRWrite,   1'b0);
        check({ctx, ".RegWrite"},  RegWrite,  1'b0);
        check({ctx, ".MemWrite"},  MemWrite,  1'b0);
        check({ctx, ".Illegal"},   Illegal,   1'b0);
        check({ctx, ".ResultSrc"}, ResultSrc, 2'd2);
        check({ctx, ".ALUSrcB"},   ALUSrcB,   2'd2);
    endtask

    logic [6:0] ops[8];

    initial begin
        // Held in reset with MemReady high: FETCH state but no enables
        #1;
        check_reset_quiet("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        do_instr("lw",      7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0);
        do_instr("sub",     7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
        do_instr("addi",    7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
        do_instr("slt",     7'b0110011, 3'd2, 1'b0, 1'b0, 0, 0);
        do_instr("beq_z1",  7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
        do_instr("beq_z0",  7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("sw_stall",7'b0100011, 3'd2, 1'b0, 1'b0, 2, 3);
        do_instr("jal",     7'b1101111, 3'd5, 1'b1, 1'b1, 1, 0);
        do_instr("bad_op",  7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
        do_instr("bad_f3",  7'b0010011, 3'd3, 1'b0, 1'b0, 0, 0);

        // Abort in MEMWB: RegWrite must drop as soon as reset asserts
        op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
        build(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0);
        run("lw_abort", 4);
        MemReady = 1'b1;
        #1;
        check("lw_abort.memwb_RegWrite", RegWrite, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_quiet("lw_abort.rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_instr("after_rst", 7'b0110011, 3'd7, 1'b0, 1'b0, 0, 0);

        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;
        ops[6] = 7'b1111111; ops[7] = 7'b0000000;
        for (int k = 0; k < 120; k++) begin
            logic [6:0] o;
            o = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 7'($urandom);
            do_instr($sformatf("rnd%0d", k), o, 3'($urandom), rnd_bit(), rnd_bit(),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
